mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning maximum number of cycles a memory-access state waits for mem_ready (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning wait-counter width; CNT_W SHALL hold TIMEOUT.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 opcode  in  6  instruction[31:26] from the external instruction register.
REQ-006 funct  in  6  instruction[5:0].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completes the current request this cycle.
REQ-009 mem_req  out  1  memory request active.
REQ-010 memwrite  out  1  request is a store.
REQ-011 iord  out  1  address select: 0 = PC, 1 = ALUOut.
REQ-012 irwrite  out  1  load instruction register.
REQ-013 pcen  out  1  PC write enable.
REQ-014 regwrite, regdst, memtoreg, alusrca  out  1 each  datapath selects.
REQ-015 alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-016 pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-018 state  out  4  current state code, for debug.
REQ-019 illegal  out  1  one-cycle pulse on an unknown opcode.
REQ-020 timeout  out  1  one-cycle pulse on a memory wait overrun.

Function
REQ-021 SHALL implement a 12-state FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12..15 SHALL go to FETCH.
REQ-022 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00; irwrite=pcen=mem_ready; exit to DECODE only when mem_ready=1.
REQ-023 DECODE: alusrcb=11, alucontrol=010; next state by opcode: 100011/101011 to MEMADR, 000000 to EXECUTE, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP; any other opcode goes to FETCH with illegal=1 for that cycle.
REQ-024 MEMADR: alusrca=1, alusrcb=10, alucontrol=010; opcode 100011 to MEMRD, else MEMWR.
REQ-025 MEMRD: mem_req=1, iord=1; to MEMWB on mem_ready. MEMWB: regwrite=1, memtoreg=1, regdst=0; to FETCH.
REQ-026 MEMWR: mem_req=1, memwrite=1, iord=1; to FETCH on mem_ready.
REQ-027 EXECUTE: alusrca=1, alusrcb=00; alucontrol from funct: 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111, other to 010; to ALUWB.
REQ-028 ALUWB: regwrite=1, regdst=1, memtoreg=0; to FETCH.
REQ-029 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero; to FETCH.
REQ-030 ADDIEX: alusrca=1, alusrcb=10, alucontrol=010; to ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0; to FETCH.
REQ-031 JUMP: pcsrc=10, pcen=1; to FETCH.
REQ-032 Any output not listed for a state SHALL be 0.
REQ-033 Wait counter: cleared on entry to each of FETCH, MEMRD and MEMWR; increments by 1 each cycle spent in one of those states with mem_ready=0; saturates, no wrap.
REQ-034 When the counter equals TIMEOUT and mem_ready=0: timeout=1 that cycle, next state FETCH, and pcen, irwrite, regwrite and memwrite SHALL all be 0 for that cycle.
REQ-035 When mem_ready=1 in the same cycle the counter equals TIMEOUT, mem_ready SHALL win: normal transition, no timeout pulse.
REQ-036 Latencies with zero-wait memory: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.

Reset
REQ-037 While rst=1: state=FETCH, counter=0, every output 0 (including mem_req, illegal and timeout), regardless of clk.
REQ-038 rst asserted in any state SHALL abort the instruction immediately, with no further register, memory or PC write.
REQ-039 The first mem_req=1 SHALL appear in the cycle after rst deasserts.

Verification
REQ-040 Reset, then opcode=100011 with mem_ready always 1: states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4.
REQ-041 beq (000100) with zero=1: pcen=1 and pcsrc=01 in BRANCH; with zero=0, pcen=0.
REQ-042 FETCH with mem_ready held 0 and TIMEOUT=15: 15 wait cycles, then timeout pulse for 1 cycle, re-enter FETCH, irwrite never 1.
REQ-043 mem_ready rises on the cycle the counter equals TIMEOUT in MEMWR: memwrite=1, timeout=0, next state FETCH.
REQ-044 opcode=111111 in DECODE: illegal=1 for 1 cycle, next state FETCH, no regwrite/memwrite/pcen.
REQ-045 rst asserted mid-MEMWR: mem_req and memwrite go to 0 without a clock edge; after release the FSM restarts at FETCH.

Source files
------------

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if
// Bundles the signals between the multicycle MIPS controller and its
// datapath/memory.
//   master : controller side (drives the control word, reads opcode/flags)
//   slave  : datapath/memory side
// Signals:
//   opcode[5:0], funct[5:0], zero, mem_ready        datapath/memory -> ctrl
//   mem_req, memwrite, iord, irwrite, pcen,
//   regwrite, regdst, memtoreg, alusrca,
//   alusrcb[1:0], pcsrc[1:0], alucontrol[2:0],
//   state[3:0], illegal, timeout                     ctrl -> datapath/memory
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;
  logic       timeout;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, alucontrol, state,
           illegal, timeout
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, alucontrol, state,
           illegal, timeout
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j) with a
// memory-wait watchdog.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset; forces every output to 0
//   bus  : mips_mc_ctrl_if.master (opcode/funct/zero/mem_ready in,
//          control word, debug state, illegal and timeout pulses out)
// Parameters:
//   TIMEOUT : max cycles a memory state waits for mem_ready (1..255)
//   CNT_W   : wait-counter width, must be able to hold TIMEOUT
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4
// DECODE  | dispatch on opcode, precompute branch target
// MEMADR  | compute load/store address
// MEMRD   | load data read
// MEMWB   | load writeback to rt
// MEMWR   | store data write
// EXECUTE | R-type ALU op
// ALUWB   | R-type writeback to rd
// BRANCH  | beq compare, PC <= target if zero
// ADDIEX  | addi ALU op
// ADDIWB  | addi writeback to rt
// JUMP    | PC <= jump target
module mips_mc_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait_st;
  logic             w_tmo;
  logic             w_op_ok;

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                     (r_state == S_MEMWR);
  // mem_ready in the terminal-count cycle still completes normally.
  assign w_tmo     = w_wait_st && !bus.mem_ready && (r_cnt == CNT_W'(TIMEOUT));
  assign w_op_ok   = (bus.opcode == OP_LW)   || (bus.opcode == OP_SW)   ||
                     (bus.opcode == OP_RTYPE) || (bus.opcode == OP_BEQ) ||
                     (bus.opcode == OP_ADDI) || (bus.opcode == OP_J);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      // Only a stalled wait state keeps counting; any other cycle either
      // leaves the state or is not a wait state, so the next wait-state
      // entry always starts from zero.
      if (w_wait_st && !bus.mem_ready && !w_tmo) begin
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      if (w_tmo) begin
        r_state <= S_FETCH;
      end else begin
        case (r_state)
          S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
          S_DECODE:
            case (bus.opcode)
              OP_LW, OP_SW: r_state <= S_MEMADR;
              OP_RTYPE:     r_state <= S_EXECUTE;
              OP_BEQ:       r_state <= S_BRANCH;
              OP_ADDI:      r_state <= S_ADDIEX;
              OP_J:         r_state <= S_JUMP;
              default:      r_state <= S_FETCH;
            endcase
          S_MEMADR:  r_state <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
          S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
          S_MEMWR:   if (bus.mem_ready) r_state <= S_FETCH;
          S_EXECUTE: r_state <= S_ALUWB;
          S_ADDIEX:  r_state <= S_ADDIWB;
          default:   r_state <= S_FETCH;
        endcase
      end
    end
  end

  // Outputs decode from the state register but several of them qualify
  // same-cycle inputs (mem_ready, zero, opcode), and all must drop as soon
  // as rst rises, so this block is combinational and gated by rst.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcen       = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = 3'b000;
    bus.illegal    = 1'b0;
    bus.timeout    = 1'b0;
    if (!rst) begin
      bus.timeout = w_tmo;
      case (r_state)
        S_FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alusrcb    = 2'b01;
          bus.alucontrol = 3'b010;
          bus.irwrite    = bus.mem_ready;
          bus.pcen       = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alusrcb    = 2'b11;
          bus.alucontrol = 3'b010;
          bus.illegal    = !w_op_ok;
        end
        S_MEMADR, S_ADDIEX: begin
          bus.alusrca    = 1'b1;
          bus.alusrcb    = 2'b10;
          bus.alucontrol = 3'b010;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.memwrite = !w_tmo;
        end
        S_EXECUTE: begin
          bus.alusrca = 1'b1;
          case (bus.funct)
            6'b100010: bus.alucontrol = 3'b110;
            6'b100100: bus.alucontrol = 3'b000;
            6'b100101: bus.alucontrol = 3'b001;
            6'b101010: bus.alucontrol = 3'b111;
            default:   bus.alucontrol = 3'b010;
          endcase
        end
        S_ALUWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alusrca    = 1'b1;
          bus.alucontrol = 3'b110;
          bus.pcsrc      = 2'b01;
          bus.pcen       = bus.zero;
        end
        S_ADDIWB: bus.regwrite = 1'b1;
        S_JUMP: begin
          bus.pcsrc = 2'b10;
          bus.pcen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010,
                         IL = 6'b111111;

  // {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,memtoreg,alusrca,
  //  alusrcb[1:0],pcsrc[1:0],alucontrol[2:0],illegal,timeout}
  localparam logic [17:0] C_NONE  = 18'b0;
  localparam logic [17:0] C_FWAIT = {9'b100000000, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] C_FRDY  = {9'b100110000, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] C_FTMO  = {9'b100000000, 2'b01, 2'b00, 3'b010, 2'b01};
  localparam logic [17:0] C_DEC   = {9'b000000000, 2'b11, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] C_DILL  = {9'b000000000, 2'b11, 2'b00, 3'b010, 2'b10};
  localparam logic [17:0] C_MADR  = {9'b000000001, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] C_MRD   = {9'b101000000, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_MWB   = {9'b000001010, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_MWR   = {9'b111000000, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_MWRT  = {9'b101000000, 2'b00, 2'b00, 3'b000, 2'b01};
  localparam logic [17:0] C_AWB   = {9'b000001100, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_BR1   = {9'b000010001, 2'b00, 2'b01, 3'b110, 2'b00};
  localparam logic [17:0] C_BR0   = {9'b000000001, 2'b00, 2'b01, 3'b110, 2'b00};
  localparam logic [17:0] C_AIWB  = {9'b000001000, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_JMP   = {9'b000010000, 2'b00, 2'b10, 3'b000, 2'b00};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Drive one cycle of inputs just after the rising edge and queue what the
  // DUT must present for that cycle.
  task automatic cyc(input string tag, input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic mr,
                     input logic [3:0] es, input logic [17:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
    e.tag = tag;
    e.st  = es;
    e.ctl = ec;
    sb.push_back(e);
  endtask

  // Monitor: compare on the falling edge whenever a cycle is pending.
  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcen,
             bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
             bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal, bus.timeout};
      n_chk++;
      if (bus.state !== e.st) begin
        n_err++;
        $display("FAIL %s state: got %0d expected %0d", e.tag, bus.state, e.st);
      end
      n_chk++;
      if (act !== e.ctl) begin
        n_err++;
        $display("FAIL %s ctl: got %b expected %b", e.tag, act, e.ctl);
      end
    end
  end

  logic [5:0]  fn_tab [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
  logic [17:0] ex_tab [5] = '{
    {9'b000000001, 2'b00, 2'b00, 3'b110, 2'b00},
    {9'b000000001, 2'b00, 2'b00, 3'b000, 2'b00},
    {9'b000000001, 2'b00, 2'b00, 3'b001, 2'b00},
    {9'b000000001, 2'b00, 2'b00, 3'b111, 2'b00},
    {9'b000000001, 2'b00, 2'b00, 3'b010, 2'b00}};

  initial begin
    bus.opcode = LW; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    cyc("reset0", 1, LW, 0, 0, 1, 0, C_NONE);
    cyc("reset1", 1, LW, 0, 0, 1, 0, C_NONE);

    // lw, zero-wait memory: 5 cycles
    cyc("lw_fetch", 0, LW, 0, 0, 1, 0, C_FRDY);
    cyc("lw_dec",   0, LW, 0, 0, 1, 1, C_DEC);
    cyc("lw_madr",  0, LW, 0, 0, 1, 2, C_MADR);
    cyc("lw_mrd",   0, LW, 0, 0, 1, 3, C_MRD);
    cyc("lw_mwb",   0, LW, 0, 0, 1, 4, C_MWB);

    // sw: 4 cycles
    cyc("sw_fetch", 0, SW, 0, 0, 1, 0, C_FRDY);
    cyc("sw_dec",   0, SW, 0, 0, 1, 1, C_DEC);
    cyc("sw_madr",  0, SW, 0, 0, 1, 2, C_MADR);
    cyc("sw_mwr",   0, SW, 0, 0, 1, 5, C_MWR);

    // R-type with each funct plus an unknown funct (defaults to add)
    for (int i = 0; i < 5; i++) begin
      cyc("r_fetch", 0, RT, fn_tab[i], 0, 1, 0, C_FRDY);
      cyc("r_dec",   0, RT, fn_tab[i], 0, 1, 1, C_DEC);
      cyc("r_exec",  0, RT, fn_tab[i], 0, 1, 6, ex_tab[i]);
      cyc("r_wb",    0, RT, fn_tab[i], 0, 1, 7, C_AWB);
    end

    // beq taken / not taken
    cyc("beq1_fetch", 0, BQ, 0, 1, 1, 0, C_FRDY);
    cyc("beq1_dec",   0, BQ, 0, 1, 1, 1, C_DEC);
    cyc("beq1_br",    0, BQ, 0, 1, 1, 8, C_BR1);
    cyc("beq0_fetch", 0, BQ, 0, 0, 1, 0, C_FRDY);
    cyc("beq0_dec",   0, BQ, 0, 0, 1, 1, C_DEC);
    cyc("beq0_br",    0, BQ, 0, 0, 1, 8, C_BR0);

    // addi, j, illegal
    cyc("addi_fetch", 0, AI, 0, 0, 1, 0,  C_FRDY);
    cyc("addi_dec",   0, AI, 0, 0, 1, 1,  C_DEC);
    cyc("addi_ex",    0, AI, 0, 0, 1, 9,  C_MADR);
    cyc("addi_wb",    0, AI, 0, 0, 1, 10, C_AIWB);
    cyc("j_fetch",    0, JP, 0, 0, 1, 0,  C_FRDY);
    cyc("j_dec",      0, JP, 0, 0, 1, 1,  C_DEC);
    cyc("j_jump",     0, JP, 0, 0, 1, 11, C_JMP);
    cyc("ill_fetch",  0, IL, 0, 0, 1, 0,  C_FRDY);
    cyc("ill_dec",    0, IL, 0, 0, 1, 1,  C_DILL);

    // FETCH stalled: 15 wait cycles, timeout pulse, fresh FETCH
    for (int i = 0; i < 15; i++) cyc("f_wait", 0, JP, 0, 0, 0, 0, C_FWAIT);
    cyc("f_tmo",    0, JP, 0, 0, 0, 0,  C_FTMO);
    cyc("f_rewait", 0, JP, 0, 0, 0, 0,  C_FWAIT);
    cyc("f_rdy",    0, JP, 0, 0, 1, 0,  C_FRDY);
    cyc("f_dec",    0, JP, 0, 0, 1, 1,  C_DEC);
    cyc("f_jump",   0, JP, 0, 0, 1, 11, C_JMP);

    // MEMWR: mem_ready arrives exactly at the terminal count
    cyc("swl_fetch", 0, SW, 0, 0, 1, 0, C_FRDY);
    cyc("swl_dec",   0, SW, 0, 0, 1, 1, C_DEC);
    cyc("swl_madr",  0, SW, 0, 0, 1, 2, C_MADR);
    for (int i = 0; i < 15; i++) cyc("swl_wait", 0, SW, 0, 0, 0, 5, C_MWR);
    cyc("swl_late",  0, SW, 0, 0, 1, 5, C_MWR);
    cyc("swl_next",  0, SW, 0, 0, 0, 0, C_FWAIT);

    // MEMWR overrun: timeout, no memwrite, back to FETCH
    cyc("swt_fetch", 0, SW, 0, 0, 1, 0, C_FRDY);
    cyc("swt_dec",   0, SW, 0, 0, 1, 1, C_DEC);
    cyc("swt_madr",  0, SW, 0, 0, 1, 2, C_MADR);
    for (int i = 0; i < 15; i++) cyc("swt_wait", 0, SW, 0, 0, 0, 5, C_MWR);
    cyc("swt_tmo",   0, SW, 0, 0, 0, 5, C_MWRT);
    cyc("swt_next",  0, SW, 0, 0, 1, 0, C_FRDY);

    // reset asserted mid-MEMWR, between clock edges
    cyc("swr_dec",   0, SW, 0, 0, 1, 1, C_DEC);
    cyc("swr_madr",  0, SW, 0, 0, 1, 2, C_MADR);
    cyc("swr_mwr",   0, SW, 0, 0, 0, 5, C_MWR);
    cyc("rst_mid",   1, SW, 0, 0, 0, 0, C_NONE);
    cyc("rst_hold",  1, SW, 0, 0, 1, 0, C_NONE);
    cyc("rel_fetch", 0, LW, 0, 0, 1, 0, C_FRDY);
    cyc("rel_dec",   0, LW, 0, 0, 1, 1, C_DEC);
    cyc("rel_madr",  0, LW, 0, 0, 1, 2, C_MADR);
    cyc("rel_mrd",   0, LW, 0, 0, 1, 3, C_MRD);
    cyc("rel_mwb",   0, LW, 0, 0, 1, 4, C_MWB);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
